// File: rtl/importance_topk_select.sv
// importance_topk_select: collects one frame of SEQ_LEN unsigned importance scores, tracks the
// TOPK largest in a sorted insertion table and presents a keep mask plus the minimum kept score
// (threshold) through a valid/ready handshake.
module importance_topk_select #(
  parameter int unsigned width   = 8,
  parameter int unsigned SEQ_LEN = 4,
  parameter int unsigned TOPK    = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 imp_valid_i,
  output logic                 imp_ready_o,
  input  logic [2*width-1:0]   importance_i,
  output logic                 busy_o,
  output logic                 mask_valid_o,
  input  logic                 mask_ready_i,
  output logic [SEQ_LEN-1:0]   keep_mask_o,
  output logic [2*width-1:0]   threshold_o
);

  localparam int unsigned VW   = 2 * width;
  localparam int unsigned IdxW = $clog2(SEQ_LEN);

  typedef enum logic [1:0] {StIdle, StCollect, StOutput} state_e;

  state_e state_q, state_d;

  logic [IdxW-1:0]    cnt_q, cnt_d;
  logic [VW-1:0]      val_q [TOPK];
  logic [VW-1:0]      val_d [TOPK];
  logic [IdxW-1:0]    idx_q [TOPK];
  logic [IdxW-1:0]    idx_d [TOPK];
  logic               vld_q [TOPK];
  logic               vld_d [TOPK];
  logic [SEQ_LEN-1:0] keep_mask_q, keep_mask_d;
  logic [VW-1:0]      threshold_q, threshold_d;

  // Table contents after inserting the current token.
  logic [VW-1:0]      ins_val [TOPK];
  logic [IdxW-1:0]    ins_idx [TOPK];
  logic               ins_vld [TOPK];
  // Entry above each slot, used when the table shifts down.
  logic [VW-1:0]      prev_val [TOPK];
  logic [IdxW-1:0]    prev_idx [TOPK];
  logic               prev_vld [TOPK];

  logic               frame_start;
  logic               accept;
  logic               last_tok;
  logic [SEQ_LEN-1:0] mask_new;

  assign frame_start = (state_q == StIdle) && start_i;
  assign accept      = (state_q == StCollect) && imp_valid_i;
  assign last_tok    = (cnt_q == IdxW'(SEQ_LEN - 1));

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start_i) state_d = StCollect;
      StCollect: if (accept && last_tok) state_d = StOutput;
      StOutput:  if (mask_ready_i) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Handshake and status outputs decoded from the registered state.
  always_comb begin
    imp_ready_o  = 1'b0;
    busy_o       = 1'b0;
    mask_valid_o = 1'b0;
    unique case (state_q)
      StIdle: ;
      StCollect: begin
        imp_ready_o = 1'b1;
        busy_o      = 1'b1;
      end
      StOutput: begin
        busy_o       = 1'b1;
        mask_valid_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign keep_mask_o = keep_mask_q;
  assign threshold_o = threshold_q;

  // Neighbour view of the table for the shift-down path.
  always_comb begin
    for (int unsigned i = 0; i < TOPK; i++) begin
      prev_val[i] = '0;
      prev_idx[i] = '0;
      prev_vld[i] = 1'b0;
    end
    for (int unsigned i = 1; i < TOPK; i++) begin
      prev_val[i] = val_q[i-1];
      prev_idx[i] = idx_q[i-1];
      prev_vld[i] = vld_q[i-1];
    end
  end

  // Sorted insertion: new value lands at the first empty or strictly smaller slot, so equal
  // scores keep the earlier token; everything below moves down one place.
  always_comb begin
    logic found;
    found = 1'b0;
    for (int unsigned i = 0; i < TOPK; i++) begin
      ins_val[i] = val_q[i];
      ins_idx[i] = idx_q[i];
      ins_vld[i] = vld_q[i];
      if (found) begin
        ins_val[i] = prev_val[i];
        ins_idx[i] = prev_idx[i];
        ins_vld[i] = prev_vld[i];
      end else if (!vld_q[i] || (val_q[i] < importance_i)) begin
        ins_val[i] = importance_i;
        ins_idx[i] = cnt_q;
        ins_vld[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // Keep mask built from the table as it will stand after the final token.
  always_comb begin
    mask_new = '0;
    for (int unsigned i = 0; i < TOPK; i++) begin
      if (ins_vld[i]) mask_new[ins_idx[i]] = 1'b1;
    end
  end

  // Datapath next-state: counter, table and result registers.
  always_comb begin
    cnt_d       = cnt_q;
    keep_mask_d = keep_mask_q;
    threshold_d = threshold_q;
    for (int unsigned i = 0; i < TOPK; i++) begin
      val_d[i] = val_q[i];
      idx_d[i] = idx_q[i];
      vld_d[i] = vld_q[i];
    end
    if (frame_start) begin
      cnt_d       = '0;
      keep_mask_d = '0;
      threshold_d = '0;
      for (int unsigned i = 0; i < TOPK; i++) begin
        val_d[i] = '0;
        idx_d[i] = '0;
        vld_d[i] = 1'b0;
      end
    end else if (accept) begin
      cnt_d = cnt_q + IdxW'(1);
      for (int unsigned i = 0; i < TOPK; i++) begin
        val_d[i] = ins_val[i];
        idx_d[i] = ins_idx[i];
        vld_d[i] = ins_vld[i];
      end
      if (last_tok) begin
        keep_mask_d = mask_new;
        threshold_d = ins_val[TOPK-1];
      end
    end
  end

  // Datapath registers; reset discards any partial frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      keep_mask_q <= '0;
      threshold_q <= '0;
      for (int unsigned i = 0; i < TOPK; i++) begin
        val_q[i] <= '0;
        idx_q[i] <= '0;
        vld_q[i] <= 1'b0;
      end
    end else begin
      cnt_q       <= cnt_d;
      keep_mask_q <= keep_mask_d;
      threshold_q <= threshold_d;
      for (int unsigned i = 0; i < TOPK; i++) begin
        val_q[i] <= val_d[i];
        idx_q[i] <= idx_d[i];
        vld_q[i] <= vld_d[i];
      end
    end
  end

endmodule

// File: tb/tb_importance_topk_select.sv
// Directed bench for importance_topk_select (SEQ_LEN=4, TOPK=2, width=8) with a closing
// randomised section checked against an independent rank-based model.
module tb_importance_topk_select;

  logic        clk;
  logic        rst;
  logic        start;
  logic        imp_valid;
  logic        imp_ready;
  logic [15:0] importance;
  logic        busy;
  logic        mask_valid;
  logic        mask_ready;
  logic [3:0]  keep_mask;
  logic [15:0] threshold;

  int checks;
  int failures;

  importance_topk_select #(
    .width  (8),
    .SEQ_LEN(4),
    .TOPK   (2)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .imp_valid_i (imp_valid),
    .imp_ready_o (imp_ready),
    .importance_i(importance),
    .busy_o      (busy),
    .mask_valid_o(mask_valid),
    .mask_ready_i(mask_ready),
    .keep_mask_o (keep_mask),
    .threshold_o (threshold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_imp_ready"}, 32'(imp_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_mask_valid"}, 32'(mask_valid), 32'd0);
  endtask

  // Rank-based reference: token i is kept when fewer than TOPK tokens beat it, where a tie is
  // won by the lower index.
  function automatic void model(input logic [63:0] vals, output logic [3:0] m,
                                output logic [15:0] th);
    m  = '0;
    th = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      int rank;
      rank = 0;
      for (int j = 0; j < 4; j++) begin
        if (vals[16*j +: 16] > vals[16*i +: 16] ||
            (vals[16*j +: 16] == vals[16*i +: 16] && j < i)) rank++;
      end
      if (rank < 2) begin
        m[i] = 1'b1;
        if (vals[16*i +: 16] < th) th = vals[16*i +: 16];
      end
    end
  endfunction

  // Runs one frame from IDLE; gap < 0 selects a random gap of 0..3 cycles per token.
  // Leaves the DUT in OUTPUT with the result checked.
  task automatic run_frame(input string tag, input logic [63:0] vals, input int gap,
                           input logic [3:0] exp_mask, input logic [15:0] exp_thr);
    int g;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy_collect"}, 32'(busy), 32'd1);
    for (int t = 0; t < 4; t++) begin
      check({tag, "_imp_ready"}, 32'(imp_ready), 32'd1);
      imp_valid  = 1'b1;
      importance = vals[16*t +: 16];
      step();
      imp_valid  = 1'b0;
      importance = 16'hDEAD;
      if (t < 3) begin
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        for (int k = 0; k < g; k++) begin
          check({tag, "_gap_ready"}, 32'(imp_ready), 32'd1);
          check({tag, "_gap_valid"}, 32'(mask_valid), 32'd0);
          step();
        end
      end
    end
    check({tag, "_mask_valid"}, 32'(mask_valid), 32'd1);
    check({tag, "_keep_mask"}, 32'(keep_mask), 32'(exp_mask));
    check({tag, "_threshold"}, 32'(threshold), 32'(exp_thr));
    check({tag, "_ready_out"}, 32'(imp_ready), 32'd0);
    check({tag, "_busy_out"}, 32'(busy), 32'd1);
  endtask

  task automatic handshake(input string tag, input logic [3:0] exp_mask,
                           input logic [15:0] exp_thr);
    mask_ready = 1'b1;
    step();
    mask_ready = 1'b0;
    check_idle({tag, "_hs"});
    check({tag, "_hold_mask"}, 32'(keep_mask), 32'(exp_mask));
    check({tag, "_hold_thr"}, 32'(threshold), 32'(exp_thr));
  endtask

  initial begin
    logic [63:0] vals;
    logic [3:0]  em;
    logic [15:0] et;
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    start      = 1'b0;
    imp_valid  = 1'b0;
    importance = '0;
    mask_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_idle("reset");
    check("reset_mask", 32'(keep_mask), 32'd0);
    check("reset_thr", 32'(threshold), 32'd0);

    // IDLE ignores imp_valid.
    imp_valid  = 1'b1;
    importance = 16'd99;
    step();
    imp_valid = 1'b0;
    check_idle("idle_ignore");

    // Basic frame.
    run_frame("basic", {16'd40, 16'd30, 16'd50, 16'd10}, 0, 4'b1010, 16'd40);
    handshake("basic", 4'b1010, 16'd40);

    // Ties.
    run_frame("tie_all", {16'd20, 16'd20, 16'd20, 16'd20}, 0, 4'b0011, 16'd20);
    handshake("tie_all", 4'b0011, 16'd20);
    run_frame("tie_part", {16'd9, 16'd9, 16'd9, 16'd5}, 0, 4'b0110, 16'd9);
    handshake("tie_part", 4'b0110, 16'd9);

    // Extremes with 3-cycle gaps.
    run_frame("extreme", {16'h0000, 16'hFFFE, 16'h0000, 16'hFFFF}, 3, 4'b0101, 16'hFFFE);
    handshake("extreme", 4'b0101, 16'hFFFE);

    // Backpressure with a stray start.
    run_frame("bp", {16'd1, 16'd8, 16'd3, 16'd7}, 0, 4'b0101, 16'd7);
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      step();
      start = 1'b0;
      check("bp_valid", 32'(mask_valid), 32'd1);
      check("bp_mask", 32'(keep_mask), 32'd5);
      check("bp_thr", 32'(threshold), 32'd7);
      check("bp_ready", 32'(imp_ready), 32'd0);
    end
    handshake("bp", 4'b0101, 16'd7);
    step();
    check_idle("bp_stray_start");

    // Reset mid-frame after two accepted tokens.
    start = 1'b1;
    step();
    start = 1'b0;
    imp_valid = 1'b1;
    importance = 16'd200;
    step();
    importance = 16'd100;
    step();
    imp_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("midrst");
    check("midrst_mask", 32'(keep_mask), 32'd0);
    check("midrst_thr", 32'(threshold), 32'd0);
    run_frame("after_rst", {16'd4, 16'd3, 16'd2, 16'd1}, 0, 4'b1100, 16'd3);
    handshake("after_rst", 4'b1100, 16'd3);

    // Back-to-back: start issued in the first IDLE cycle after the handshake.
    run_frame("b2b_a", {16'd5, 16'd6, 16'd7, 16'd8}, 0, 4'b0011, 16'd7);
    mask_ready = 1'b1;
    step();
    mask_ready = 1'b0;
    run_frame("b2b_b", {16'd8, 16'd7, 16'd6, 16'd5}, 0, 4'b1100, 16'd7);
    handshake("b2b_b", 4'b1100, 16'd7);

    // Random frames against the model.
    for (int f = 0; f < 500; f++) begin
      int n;
      for (int t = 0; t < 4; t++) begin
        vals[16*t +: 16] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 7))
                                                        : 16'($urandom);
      end
      model(vals, em, et);
      run_frame("rand", vals, -1, em, et);
      n = int'($urandom_range(0, 3));
      for (int c = 0; c < n; c++) begin
        step();
        check("rand_hold", 32'(keep_mask), 32'(em));
      end
      handshake("rand", em, et);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
